// File: rtl/dechuff_unstuff_if.sv
// Byte-stream handshake bundle between the raw reader, the unstuffer and
// the two consumers (Huffman data stream and marker stream).
interface dechuff_unstuff_if;
  logic [7:0] rawbyte_d;
  logic       rawbyte_e;
  logic       rawbyte_v;
  logic       rawbyte_b;

  logic [7:0] filebyte_d;
  logic       filebyte_e;
  logic       filebyte_v;
  logic       filebyte_b;

  logic [7:0] marker_d;
  logic       marker_e;
  logic       marker_v;
  logic       marker_b;

  // Environment side: drives raw tokens and downstream back-pressure.
  modport master (
    output rawbyte_d, rawbyte_e, rawbyte_v, filebyte_b, marker_b,
    input  rawbyte_b, filebyte_d, filebyte_e, filebyte_v,
    input  marker_d, marker_e, marker_v
  );

  // Unstuffer side.
  modport slave (
    input  rawbyte_d, rawbyte_e, rawbyte_v, filebyte_b, marker_b,
    output rawbyte_b, filebyte_d, filebyte_e, filebyte_v,
    output marker_d, marker_e, marker_v
  );
endinterface

// File: rtl/dechuff_unstuff.sv
// JPEG entropy-segment unstuffer: removes 0x00 stuffing after 0xFF,
// drops 0xFF fill bytes, splits markers onto their own stream and
// terminates both streams on EOI or end-of-stream.
//
// state  | meaning
// DATA   | passing data bytes through
// GOT_FF | 0xFF seen, waiting for the byte that qualifies it
// DONE   | stream terminated; input is swallowed until reset
module dechuff_unstuff (
  input  logic              clock,
  input  logic              reset,
  dechuff_unstuff_if.slave  bus,
  output logic [15:0]       stuff_count
);

  typedef enum logic [1:0] {S_DATA, S_GOT_FF, S_DONE} state_t;

  state_t     state, state_nxt;
  logic       accept;
  logic       ld_f, ld_m, inc_stuff;
  logic [7:0] ld_f_d, ld_m_d;
  logic       ld_f_e, ld_m_e;

  // Stall upstream while either occupied slot is blocked; DONE never stalls.
  always_comb begin
    bus.rawbyte_b = 1'b0;
    if (state != S_DONE)
      bus.rawbyte_b = (bus.filebyte_v && bus.filebyte_b) ||
                      (bus.marker_v && bus.marker_b);
  end

  assign accept = bus.rawbyte_v && !bus.rawbyte_b;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= S_DATA;
    else       state <= state_nxt;
  end

  // Next-state decode on each accepted token.
  always_comb begin
    state_nxt = state;
    if (accept) begin
      case (state)
        S_DATA: begin
          if (bus.rawbyte_e)              state_nxt = S_DONE;
          else if (bus.rawbyte_d == 8'hFF) state_nxt = S_GOT_FF;
        end
        S_GOT_FF: begin
          if (bus.rawbyte_e)               state_nxt = S_DONE;
          else if (bus.rawbyte_d == 8'hFF) state_nxt = S_GOT_FF;
          else if (bus.rawbyte_d == 8'hD9) state_nxt = S_DONE;
          else                             state_nxt = S_DATA;
        end
        default: state_nxt = S_DONE;
      endcase
    end
  end

  // Slot-load and counter-increment decode.
  always_comb begin
    ld_f      = 1'b0;
    ld_f_d    = 8'h00;
    ld_f_e    = 1'b0;
    ld_m      = 1'b0;
    ld_m_d    = 8'h00;
    ld_m_e    = 1'b0;
    inc_stuff = 1'b0;
    if (accept && state != S_DONE) begin
      if (bus.rawbyte_e) begin
        // End of stream: pending 0xFF is dropped, both streams get an e-token.
        ld_f   = 1'b1;
        ld_f_e = 1'b1;
        ld_m   = 1'b1;
        ld_m_e = 1'b1;
      end else if (state == S_DATA) begin
        if (bus.rawbyte_d != 8'hFF) begin
          ld_f   = 1'b1;
          ld_f_d = bus.rawbyte_d;
        end
      end else begin
        case (bus.rawbyte_d)
          8'h00: begin
            ld_f      = 1'b1;
            ld_f_d    = 8'hFF;
            inc_stuff = 1'b1;
          end
          8'hFF: ;
          8'hD9: begin
            ld_m   = 1'b1;
            ld_m_d = 8'hD9;
            ld_f   = 1'b1;
            ld_f_e = 1'b1;
          end
          default: begin
            ld_m   = 1'b1;
            ld_m_d = bus.rawbyte_d;
          end
        endcase
      end
    end
  end

  // Filebyte slot: cleared on transfer, reload wins in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.filebyte_v <= 1'b0;
      bus.filebyte_e <= 1'b0;
      bus.filebyte_d <= 8'h00;
    end else if (ld_f) begin
      bus.filebyte_v <= 1'b1;
      bus.filebyte_e <= ld_f_e;
      bus.filebyte_d <= ld_f_d;
    end else if (bus.filebyte_v && !bus.filebyte_b) begin
      bus.filebyte_v <= 1'b0;
      bus.filebyte_e <= 1'b0;
      bus.filebyte_d <= 8'h00;
    end
  end

  // Marker slot: same discipline as the filebyte slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.marker_v <= 1'b0;
      bus.marker_e <= 1'b0;
      bus.marker_d <= 8'h00;
    end else if (ld_m) begin
      bus.marker_v <= 1'b1;
      bus.marker_e <= ld_m_e;
      bus.marker_d <= ld_m_d;
    end else if (bus.marker_v && !bus.marker_b) begin
      bus.marker_v <= 1'b0;
      bus.marker_e <= 1'b0;
      bus.marker_d <= 8'h00;
    end
  end

  // Saturating count of removed stuffing bytes.
  always_ff @(posedge clock) begin
    if (reset)
      stuff_count <= 16'h0000;
    else if (inc_stuff && stuff_count != 16'hFFFF)
      stuff_count <= stuff_count + 16'd1;
  end

endmodule

// File: tb/tb_dechuff_unstuff.sv
// Scoreboard bench for dechuff_unstuff: a stream-level reference model
// predicts both output streams, a monitor checks every transfer.
module tb_dechuff_unstuff;

  typedef struct packed {
    logic       e;
    logic [7:0] d;
  } tok_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] stuff_count;

  dechuff_unstuff_if bus ();

  dechuff_unstuff dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus.slave),
    .stuff_count (stuff_count)
  );

  always #5 clock = ~clock;

  int   checks   = 0;
  int   failures = 0;
  tok_t stim[$];
  tok_t exp_f[$];
  tok_t exp_m[$];
  int   exp_stuff;
  bit   bp_rand  = 1'b0;
  bit   gap_en   = 1'b0;
  bit   hold_req = 1'b0;
  int   hold_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: scans the whole token list, resolving each 0xFF run
  // by looking ahead to the byte that follows it.
  task automatic model();
    int i = 0;
    int j;
    exp_stuff = 0;
    while (i < stim.size()) begin
      if (stim[i].e) begin
        exp_f.push_back('{1'b1, 8'h00});
        exp_m.push_back('{1'b1, 8'h00});
        break;
      end
      if (stim[i].d != 8'hFF) begin
        exp_f.push_back('{1'b0, stim[i].d});
        i++;
        continue;
      end
      j = i + 1;
      while (j < stim.size() && !stim[j].e && stim[j].d == 8'hFF) j++;
      if (j >= stim.size()) break;
      if (stim[j].e) begin
        exp_f.push_back('{1'b1, 8'h00});
        exp_m.push_back('{1'b1, 8'h00});
        break;
      end
      if (stim[j].d == 8'h00) begin
        exp_f.push_back('{1'b0, 8'hFF});
        if (exp_stuff < 65535) exp_stuff++;
      end else if (stim[j].d == 8'hD9) begin
        exp_m.push_back('{1'b0, 8'hD9});
        exp_f.push_back('{1'b1, 8'h00});
        break;
      end else begin
        exp_m.push_back('{1'b0, stim[j].d});
      end
      i = j + 1;
    end
  endtask

  // Downstream back-pressure, with an optional 5-cycle hold on filebyte.
  always @(negedge clock) begin
    if (hold_req && hold_cnt == 0 && bus.filebyte_v) begin
      hold_cnt = 5;
      hold_req = 1'b0;
    end
    bus.filebyte_b = (hold_cnt > 0) ? 1'b1 : (bp_rand ? ($urandom_range(1) == 1) : 1'b0);
    bus.marker_b   = bp_rand ? ($urandom_range(2) == 0) : 1'b0;
    if (hold_cnt > 0) begin
      #1;
      chk("hold_rawbyte_b", {31'd0, bus.rawbyte_b}, 32'd1);
      hold_cnt--;
    end
  end

  // Monitor: a transfer happens at the next rising edge when v && !b.
  always @(negedge clock) begin
    tok_t t;
    #2;
    if (!reset && bus.filebyte_v && !bus.filebyte_b) begin
      if (exp_f.size() == 0) begin
        checks++; failures++;
        $display("FAIL filebyte_unexpected: got e=%0b d=0x%0h expected none", bus.filebyte_e, bus.filebyte_d);
      end else begin
        t = exp_f.pop_front();
        chk("filebyte_tok", {23'd0, bus.filebyte_e, bus.filebyte_d}, {23'd0, t});
      end
    end
    if (!reset && bus.marker_v && !bus.marker_b) begin
      if (exp_m.size() == 0) begin
        checks++; failures++;
        $display("FAIL marker_unexpected: got e=%0b d=0x%0h expected none", bus.marker_e, bus.marker_d);
      end else begin
        t = exp_m.pop_front();
        chk("marker_tok", {23'd0, bus.marker_e, bus.marker_d}, {23'd0, t});
      end
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    bus.rawbyte_v = 1'b0;
    @(negedge clock);
    #1;
    chk("rst_filebyte", {22'd0, bus.filebyte_v, bus.filebyte_e, bus.filebyte_d}, 32'd0);
    chk("rst_marker", {22'd0, bus.marker_v, bus.marker_e, bus.marker_d}, 32'd0);
    chk("rst_stuff_count", {16'd0, stuff_count}, 32'd0);
    chk("rst_rawbyte_b", {31'd0, bus.rawbyte_b}, 32'd0);
    reset = 1'b0;
    exp_f.delete();
    exp_m.delete();
    stim.delete();
  endtask

  // Present one token until accepted; returns in the low phase after acceptance.
  task automatic send_tok(input tok_t t);
    int n = 0;
    bus.rawbyte_d = t.d;
    bus.rawbyte_e = t.e;
    bus.rawbyte_v = 1'b1;
    #1;
    while (bus.rawbyte_b && n < 200) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (bus.rawbyte_b) begin
      checks++; failures++;
      $display("FAIL accept_timeout: got rawbyte_b=1 expected acceptance of 0x%0h", t.d);
    end
    @(negedge clock);
    bus.rawbyte_v = 1'b0;
    if (gap_en && $urandom_range(3) == 0) @(negedge clock);
  endtask

  task automatic run_stream();
    model();
    foreach (stim[k]) send_tok(stim[k]);
  endtask

  task automatic drain_and_check();
    int n = 0;
    while ((exp_f.size() != 0 || exp_m.size() != 0 || bus.filebyte_v || bus.marker_v) && n < 500) begin
      @(negedge clock);
      #3;
      n++;
    end
    chk("drain_pending", exp_f.size() + exp_m.size() + {30'd0, bus.filebyte_v, bus.marker_v}, 32'd0);
    chk("stuff_count", {16'd0, stuff_count}, exp_stuff);
  endtask

  task automatic push_bytes(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3,
                            input logic [7:0] b4, input int n);
    logic [7:0] bs[5];
    bs = '{b0, b1, b2, b3, b4};
    for (int i = 0; i < n; i++) stim.push_back('{1'b0, bs[i]});
  endtask

  initial begin
    bus.rawbyte_d = 8'h00;
    bus.rawbyte_e = 1'b0;
    bus.rawbyte_v = 1'b0;
    bus.filebyte_b = 1'b0;
    bus.marker_b = 1'b0;

    // Stuffing removal with a one-cycle latency check on the first byte.
    do_reset();
    push_bytes(8'h12, 8'hFF, 8'h00, 8'h34, 8'h00, 4);
    model();
    send_tok(stim[0]);
    chk("latency_v", {23'd0, bus.filebyte_v, bus.filebyte_d}, {23'd0, 1'b1, 8'h12});
    for (int i = 1; i < 4; i++) send_tok(stim[i]);
    drain_and_check();

    // Fill byte then a non-EOI marker.
    do_reset();
    push_bytes(8'hAB, 8'hFF, 8'hFF, 8'hD3, 8'hCD, 5);
    run_stream();
    drain_and_check();

    // EOI, then a trailing byte that must be swallowed.
    do_reset();
    push_bytes(8'h55, 8'hFF, 8'hD9, 8'h77, 8'h00, 4);
    run_stream();
    drain_and_check();

    // Downstream hold of 5 cycles while upstream streams 0x01..0x0A.
    do_reset();
    for (int i = 1; i <= 10; i++) stim.push_back('{1'b0, 8'(i)});
    hold_req = 1'b1;
    run_stream();
    drain_and_check();
    chk("hold_consumed", {31'd0, hold_req}, 32'd0);

    // End-of-stream token with a pending 0xFF.
    do_reset();
    push_bytes(8'h10, 8'hFF, 8'h00, 8'h00, 8'h00, 2);
    stim.push_back('{1'b1, 8'hFF});
    run_stream();
    drain_and_check();

    // Reset while a 0xFF is pending; the following 0x00 is plain data.
    do_reset();
    push_bytes(8'h12, 8'hFF, 8'h00, 8'h00, 8'h00, 2);
    run_stream();
    drain_and_check();
    do_reset();
    push_bytes(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1);
    run_stream();
    drain_and_check();

    // Randomized streams under random back-pressure and input gaps.
    bp_rand = 1'b1;
    gap_en  = 1'b1;
    for (int s = 0; s < 30; s++) begin
      int len;
      do_reset();
      len = $urandom_range(40, 8);
      for (int i = 0; i < len; i++) begin
        int r;
        logic [7:0] b;
        r = $urandom_range(99);
        if (r < 2)       begin stim.push_back('{1'b1, 8'($urandom)}); continue; end
        else if (r < 32) b = 8'hFF;
        else if (r < 44) b = 8'h00;
        else if (r < 47) b = 8'hD9;
        else             b = 8'($urandom);
        stim.push_back('{1'b0, b});
      end
      if ($urandom_range(1) == 1) stim.push_back('{1'b1, 8'h00});
      run_stream();
      drain_and_check();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule

// File: doc/dechuff_unstuff.md
DECHUFF_UNSTUFF -- requirements
Module: dechuff_unstuff

Interface
REQ-001 No parameters; all widths fixed.
REQ-002 clock  in  1  single rising-edge clock for all state.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 rawbyte_d  in  8  raw JPEG entropy-coded byte from file reader.
REQ-005 rawbyte_e  in  1  end-of-stream token flag, qualified by rawbyte_v.
REQ-006 rawbyte_v  in  1  rawbyte token valid.
REQ-007 rawbyte_b  out  1  back-pressure to upstream; token transfers when rawbyte_v && !rawbyte_b.
REQ-008 filebyte_d  out  8  unstuffed data byte to the Huffman decoder.
REQ-009 filebyte_e  out  1  end-of-stream token flag.
REQ-010 filebyte_v  out  1  filebyte token valid.
REQ-011 filebyte_b  in  1  downstream back-pressure; transfer when filebyte_v && !filebyte_b.
REQ-012 marker_d  out  8  marker code (second byte of 0xFFxx).
REQ-013 marker_e  out  1  end-of-stream token flag on marker stream.
REQ-014 marker_v  out  1  marker token valid.
REQ-015 marker_b  in  1  marker consumer back-pressure.
REQ-016 stuff_count  out  16  count of removed 0x00 stuffing bytes, saturating at 0xFFFF.

Function
REQ-017 Each output stream has one registered token slot (d, e, v); the slot clears on transfer and may reload in the same cycle.
REQ-018 rawbyte_b = (filebyte_v && filebyte_b) || (marker_v && marker_b); in DONE, rawbyte_b = 0.
REQ-019 States DATA, GOT_FF, DONE; reset state is DATA.
REQ-020 DATA, accepted byte != 0xFF: load filebyte slot with the byte, e=0; stay DATA; latency 1 cycle (accepted edge N, filebyte_v high after N).
REQ-021 DATA, accepted 0xFF: no output; go GOT_FF.
REQ-022 GOT_FF, accepted 0x00: load filebyte slot with 0xFF; stuff_count += 1 (saturating); go DATA.
REQ-023 GOT_FF, accepted 0xFF: fill byte, no output; stay GOT_FF.
REQ-024 GOT_FF, accepted 0xD9 (EOI): load marker slot d=0xD9, e=0; load filebyte slot e=1, d=0x00; go DONE.
REQ-025 GOT_FF, any other accepted byte: load marker slot with that byte, e=0; no filebyte output; go DATA.
REQ-026 Accepted token with rawbyte_e=1 in DATA or GOT_FF: rawbyte_d ignored; pending 0xFF discarded; load filebyte slot e=1 and marker slot e=1, both d=0x00; go DONE.
REQ-027 DONE: accept and discard all input tokens; no further output loads; exit only by reset.
REQ-028 An output slot is never loaded while it holds an untransferred token (guaranteed by REQ-018).
REQ-029 Both slots load in the same cycle only for EOI and end-of-stream; both must have drained for the input to be accepted (REQ-018).

Reset
REQ-030 On reset: state DATA; filebyte_v, filebyte_e, marker_v, marker_e = 0; filebyte_d, marker_d = 0x00; stuff_count = 0; rawbyte_b = 0 in the following cycle.
REQ-031 Reset mid-stream discards pending 0xFF and any untransferred slot contents; takes priority over a same-cycle transfer.

Verification
REQ-032 Bytes 0x12,0xFF,0x00,0x34 with no back-pressure -> filebyte 0x12,0xFF,0x34 each 1 cycle after acceptance; stuff_count=1; no marker.
REQ-033 0xAB,0xFF,0xFF,0xD3,0xCD -> filebyte 0xAB,0xCD; marker 0xD3 once; stuff_count=0.
REQ-034 0x55,0xFF,0xD9 then 0x77 -> filebyte 0x55 then e-token; marker 0xD9; 0x77 accepted (rawbyte_b=0) and dropped.
REQ-035 filebyte_b held high 5 cycles with slot full, upstream streaming 0x01.. -> rawbyte_b high those 5 cycles, no token lost/duplicated; order preserved after release.
REQ-036 0x10,0xFF then rawbyte_e token -> filebyte 0x10 then e-token; marker e-token; no 0xFF emitted.
REQ-037 reset asserted while in GOT_FF with filebyte slot full -> next cycle all outputs 0, state DATA; following 0x00 emitted as data 0x00.
